// File: rtl/store_buffer.sv
// store_buffer: in-order store queue between the load/store reservation station and data memory.
//
// Stores are allocated at dispatch, filled with address/data at execute, committed by the ROB and
// drained in order to memory over a valid/ready port. Younger loads are checked against older
// in-flight stores for forwarding or stall.
//
// Optional feature macro: STORE_BUFFER_FWD_EN
//   defined   - address-matching store-to-load forwarding
//   undefined - no comparators; any load with older in-flight stores stalls
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   alloc_valid/ready/id/tail          dispatch allocation; alloc_tail carries the wrap bit
//   exec_valid/id/addr/data/funct3     AGU fill of an allocated entry
//   commit_valid/id                    ROB retirement of a store
//   flush                              drop all uncommitted entries
//   mem_req_valid/ready/addr/data/funct3  in-order drain of committed head store
//   fwd_valid/addr/tail                load lookup over [head, fwd_tail)
//   fwd_hit/data/stall                 combinational lookup result
module store_buffer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned SID_W = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    output logic [SID_W-1:0]      alloc_id,
    output logic [SID_W:0]        alloc_tail,
    input  logic                  exec_valid,
    input  logic [SID_W-1:0]      exec_id,
    input  logic [ADDR_WIDTH-1:0] exec_addr,
    input  logic [DATA_WIDTH-1:0] exec_data,
    input  logic [2:0]            exec_funct3,
    input  logic                  commit_valid,
    input  logic [SID_W-1:0]      commit_id,
    input  logic                  flush,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    output logic [2:0]            mem_req_funct3,
    input  logic                  fwd_valid,
    input  logic [ADDR_WIDTH-1:0] fwd_addr,
    input  logic [SID_W:0]        fwd_tail,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  fwd_stall
);

    typedef enum logic [1:0] {StFree, StAlloc, StReady, StCommitted} ent_state_e;

    localparam logic [SID_W:0] PtrOne = (SID_W + 1)'(1);
    localparam logic [SID_W:0] PtrFull = (SID_W + 1)'(FIFO_DEPTH);

    ent_state_e            state_q [FIFO_DEPTH];
    ent_state_e            state_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [FIFO_DEPTH];
    logic [2:0]            funct3_q[FIFO_DEPTH];

    logic [SID_W:0]   head_q, head_d, tail_q, tail_d, ncommit_q, ncommit_d, count_d;
    logic             ready_q;
    logic             do_alloc, exec_ok, commit_ok, do_drain;
    logic [SID_W-1:0] head_idx, flush_off;

    assign head_idx   = head_q[SID_W-1:0];
    assign alloc_ready = ready_q;
    assign alloc_id    = tail_q[SID_W-1:0];
    assign alloc_tail  = tail_q;

    assign mem_req_valid  = (state_q[head_idx] == StCommitted);
    assign mem_req_addr   = addr_q[head_idx];
    assign mem_req_data   = data_q[head_idx];
    assign mem_req_funct3 = funct3_q[head_idx];

    assign do_alloc  = alloc_valid && ready_q && !flush;
    // Exec only fills live, not-yet-committed entries.
    assign exec_ok   = exec_valid &&
                       (state_q[exec_id] == StAlloc || state_q[exec_id] == StReady);
    assign commit_ok = commit_valid && (state_q[commit_id] == StReady);
    assign do_drain  = mem_req_valid && mem_req_ready;

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        ncommit_d = ncommit_q;
        flush_off = '0;
        if (do_alloc) begin
            state_d[tail_q[SID_W-1:0]] = StAlloc;
            tail_d = tail_q + PtrOne;
        end
        if (exec_ok) begin
            state_d[exec_id] = StReady;
        end
        if (commit_ok) begin
            state_d[commit_id] = StCommitted;
            ncommit_d = ncommit_d + PtrOne;
        end
        if (do_drain) begin
            state_d[head_idx] = StFree;
            head_d    = head_q + PtrOne;
            ncommit_d = ncommit_d - PtrOne;
        end
        // Flush keeps only the committed run starting at the post-drain head.
        if (flush) begin
            tail_d = head_d + ncommit_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                flush_off = SID_W'(i) - head_d[SID_W-1:0];
                if ({1'b0, flush_off} >= ncommit_d) begin
                    state_d[i] = StFree;
                end
            end
        end
        count_d = tail_d - head_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            ncommit_q <= '0;
            ready_q   <= 1'b1;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                state_q[i]  <= StFree;
                addr_q[i]   <= '0;
                data_q[i]   <= '0;
                funct3_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            ncommit_q <= ncommit_d;
            ready_q   <= (count_d != PtrFull);
            state_q   <= state_d;
            if (exec_ok) begin
                addr_q[exec_id]   <= exec_addr;
                data_q[exec_id]   <= exec_data;
                funct3_q[exec_id] <= exec_funct3;
            end
        end
    end

    logic [SID_W:0] fwd_n;
    assign fwd_n = fwd_tail - head_q;

`ifdef STORE_BUFFER_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^fwd_addr[1:0];

    // Walking oldest to youngest and letting later decisions overwrite is equivalent to
    // stopping at the first decision from the youngest end.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_stall = 1'b0;
        fwd_data  = '0;
        if (fwd_valid) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if ((SID_W + 1)'(k) < fwd_n) begin
                    if (state_q[head_idx + SID_W'(k)] == StAlloc) begin
                        fwd_hit   = 1'b0;
                        fwd_stall = 1'b1;
                        fwd_data  = '0;
                    end else if ((state_q[head_idx + SID_W'(k)] == StReady ||
                                  state_q[head_idx + SID_W'(k)] == StCommitted) &&
                                 (addr_q[head_idx + SID_W'(k)][ADDR_WIDTH-1:2] ==
                                  fwd_addr[ADDR_WIDTH-1:2])) begin
                        if (funct3_q[head_idx + SID_W'(k)] == 3'b010) begin
                            fwd_hit   = 1'b1;
                            fwd_stall = 1'b0;
                            fwd_data  = data_q[head_idx + SID_W'(k)];
                        end else begin
                            fwd_hit   = 1'b0;
                            fwd_stall = 1'b1;
                            fwd_data  = '0;
                        end
                    end
                end
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_addr;

    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;
    assign fwd_stall = fwd_valid && (fwd_n != '0);
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 3;
`ifdef STORE_BUFFER_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          alloc_valid, alloc_ready;
    logic [SW-1:0] alloc_id;
    logic [SW:0]   alloc_tail;
    logic          exec_valid;
    logic [SW-1:0] exec_id;
    logic [AW-1:0] exec_addr;
    logic [DW-1:0] exec_data;
    logic [2:0]    exec_funct3;
    logic          commit_valid;
    logic [SW-1:0] commit_id;
    logic          flush;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [2:0]    mem_req_funct3;
    logic          fwd_valid;
    logic [AW-1:0] fwd_addr;
    logic [SW:0]   fwd_tail;
    logic          fwd_hit, fwd_stall;
    logic [DW-1:0] fwd_data;

    store_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .alloc_tail(alloc_tail),
        .exec_valid(exec_valid), .exec_id(exec_id), .exec_addr(exec_addr),
        .exec_data(exec_data), .exec_funct3(exec_funct3),
        .commit_valid(commit_valid), .commit_id(commit_id), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_funct3(mem_req_funct3),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_tail(fwd_tail),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]    f3;
    } mem_exp_t;
    typedef struct packed {
        logic          hit;
        logic          stall;
        logic [DW-1:0] data;
    } fwd_exp_t;

    mem_exp_t exp_mem[$];
    fwd_exp_t exp_fwd[$];
    int checks = 0;
    int errors = 0;
    bit execd[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT responses against queued expectations, away from the clock edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req_valid && mem_req_ready) begin
                if (exp_mem.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_write unexpected addr=%0h data=%0h", mem_req_addr,
                             mem_req_data);
                end else begin
                    mem_exp_t m;
                    m = exp_mem.pop_front();
                    check("mem_addr", 64'(mem_req_addr), 64'(m.addr));
                    check("mem_data", 64'(mem_req_data), 64'(m.data));
                    check("mem_funct3", 64'(mem_req_funct3), 64'(m.f3));
                end
            end
            if (fwd_valid) begin
                if (exp_fwd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fwd unexpected lookup hit=%0b stall=%0b", fwd_hit, fwd_stall);
                end else begin
                    fwd_exp_t f;
                    f = exp_fwd.pop_front();
                    check("fwd_hit", 64'(fwd_hit), 64'(f.hit));
                    check("fwd_stall", 64'(fwd_stall), 64'(f.stall));
                    check("fwd_data", 64'(fwd_data), 64'(f.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        alloc_valid = 0; exec_valid = 0; exec_id = '0; exec_addr = '0; exec_data = '0;
        exec_funct3 = '0; commit_valid = 0; commit_id = '0; flush = 0; mem_req_ready = 0;
        fwd_valid = 0; fwd_addr = '0; fwd_tail = '0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 0;
        foreach (execd[i]) execd[i] = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic do_alloc(input logic [SW-1:0] exp_id);
        check("alloc_id", 64'(alloc_id), 64'(exp_id));
        check("alloc_ready", 64'(alloc_ready), 64'd1);
        execd[exp_id] = 0;
        alloc_valid = 1;
        tick();
        alloc_valid = 0;
    endtask

    task automatic do_exec(input logic [SW-1:0] id, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [2:0] f3);
        exec_valid = 1; exec_id = id; exec_addr = a; exec_data = d; exec_funct3 = f3;
        execd[id] = 1;
        tick();
        exec_valid = 0;
    endtask

    task automatic do_commit(input logic [SW-1:0] id);
        assert (execd[id]) else $error("commit issued to an entry that was never executed");
        commit_valid = 1; commit_id = id;
        tick();
        commit_valid = 0;
    endtask

    task automatic do_fwd(input logic [AW-1:0] a, input logic [SW:0] t, input logic h,
                          input logic s, input logic [DW-1:0] d);
        fwd_exp_t f;
        f.hit = h; f.stall = s; f.data = d;
        exp_fwd.push_back(f);
        fwd_valid = 1; fwd_addr = a; fwd_tail = t;
        tick();
        fwd_valid = 0;
    endtask

    task automatic push_mem(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] f);
        mem_exp_t m;
        m.addr = a; m.data = d; m.f3 = f;
        exp_mem.push_back(m);
    endtask

    initial begin
        clear_in();
        #1 rst_n = 0;
        #2;
        check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        check("rst_alloc_id", 64'(alloc_id), 64'd0);
        check("rst_alloc_tail", 64'(alloc_tail), 64'd0);
        check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        check("rst_mem_addr", 64'(mem_req_addr), 64'd0);
        check("rst_mem_data", 64'(mem_req_data), 64'd0);
        check("rst_mem_funct3", 64'(mem_req_funct3), 64'd0);
        check("rst_fwd_hit", 64'(fwd_hit), 64'd0);
        check("rst_fwd_stall", 64'(fwd_stall), 64'd0);
        check("rst_fwd_data", 64'(fwd_data), 64'd0);
        tick();
        rst_n = 1;
        tick();

        // Fill all eight entries; a ninth request must be refused.
        for (int i = 0; i < 8; i++) begin
            check("fill_tail", 64'(alloc_tail), 64'(i));
            do_alloc(SW'(i));
        end
        check("full_ready", 64'(alloc_ready), 64'd0);
        alloc_valid = 1;
        tick();
        alloc_valid = 0;
        check("full_tail_hold", 64'(alloc_tail), 64'd8);
        check("full_ready_hold", 64'(alloc_ready), 64'd0);

        // Single sw through to memory.
        do_reset();
        do_alloc(0);
        do_exec(0, 32'h100, 32'hDEADBEEF, 3'b010);
        push_mem(32'h100, 32'hDEADBEEF, 3'b010);
        mem_req_ready = 1;
        do_commit(0);
        check("drain_valid", 64'(mem_req_valid), 64'd1);
        tick();
        mem_req_ready = 0;
        check("drain_empty_valid", 64'(mem_req_valid), 64'd0);
        check("drain_tail", 64'(alloc_tail), 64'd1);
        do_fwd(32'h100, 4'd1, 1'b0, 1'b0, 32'h0);

        // Forwarding from the youngest matching sw.
        do_reset();
        do_alloc(0);
        do_alloc(1);
        do_exec(0, 32'h200, 32'h11, 3'b010);
        do_exec(1, 32'h200, 32'h22, 3'b010);
        do_fwd(32'h202, 4'd2, FwdEn, !FwdEn, FwdEn ? 32'h22 : 32'h0);
        do_fwd(32'h200, 4'd1, FwdEn, !FwdEn, FwdEn ? 32'h11 : 32'h0);
        do_fwd(32'h204, 4'd2, 1'b0, !FwdEn, 32'h0);
        do_fwd(32'h204, 4'd0, 1'b0, 1'b0, 32'h0);

        // Unknown-address and partial-width older stores force a stall.
        do_alloc(2);
        do_fwd(32'h300, 4'd3, 1'b0, 1'b1, 32'h0);
        do_exec(2, 32'h300, 32'hAB, 3'b000);
        do_fwd(32'h300, 4'd3, 1'b0, 1'b1, 32'h0);
        do_fwd(32'h200, 4'd3, FwdEn, !FwdEn, FwdEn ? 32'h22 : 32'h0);

        // Flush keeps only the committed entry 0; an alloc in the flush cycle is dropped.
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(SW'(i));
        do_exec(0, 32'h400, 32'h44, 3'b010);
        execd[1] = 1;
        exec_valid = 1; exec_id = 1; exec_addr = 32'h400; exec_data = 32'h99;
        exec_funct3 = 3'b010; commit_valid = 1; commit_id = 0;
        tick();
        clear_in();
        flush = 1;
        alloc_valid = 1;
        tick();
        clear_in();
        check("flush_tail", 64'(alloc_tail), 64'd1);
        check("flush_ready", 64'(alloc_ready), 64'd1);
        check("flush_head_valid", 64'(mem_req_valid), 64'd1);
        check("flush_head_addr", 64'(mem_req_addr), 64'h400);
        do_fwd(32'h400, 4'd1, FwdEn, !FwdEn, FwdEn ? 32'h44 : 32'h0);
        do_alloc(1);
        do_fwd(32'h400, 4'd2, 1'b0, 1'b1, 32'h0);
        push_mem(32'h400, 32'h44, 3'b010);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;

        // Back-pressure: the head stays presented and stable, then writes exactly once.
        do_exec(1, 32'h600, 32'h66, 3'b001);
        do_commit(1);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(mem_req_valid), 64'd1);
            check("hold_addr", 64'(mem_req_addr), 64'h600);
            check("hold_data", 64'(mem_req_data), 64'h66);
            check("hold_funct3", 64'(mem_req_funct3), 64'd1);
            tick();
        end
        push_mem(32'h600, 32'h66, 3'b001);
        mem_req_ready = 1;
        tick();
        check("hold_after_valid", 64'(mem_req_valid), 64'd0);
        tick();
        mem_req_ready = 0;
        check("hold_after_tail", 64'(alloc_tail), 64'd2);

        // Asynchronous reset drops a pending drain at once.
        do_reset();
        do_alloc(0);
        do_exec(0, 32'h700, 32'h77, 3'b010);
        do_commit(0);
        check("pre_rst_valid", 64'(mem_req_valid), 64'd1);
        #2 rst_n = 0;
        #1;
        check("async_rst_valid", 64'(mem_req_valid), 64'd0);
        check("async_rst_addr", 64'(mem_req_addr), 64'd0);
        tick();
        rst_n = 1;
        tick();
        tick();

        check("mem_queue_drained", 64'(exp_mem.size()), 64'd0);
        check("fwd_queue_drained", 64'(exp_fwd.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Store queue between the load/store reservation station and data memory. It holds up to FIFO_DEPTH stores in program order from dispatch to retirement. Each store is allocated at dispatch, filled with address and data at execute, marked committed by the ROB through its store_id, and drained in order to data memory over a valid/ready port. Its load side checks every younger load against older in-flight stores and returns forwarded data, or tells the load to stall.

## Interface
- ADDR_WIDTH, 32, address width (parameter_pkg)
- DATA_WIDTH, 32, store data width (parameter_pkg)
- FIFO_DEPTH, 8, number of entries; power of two; SID_W = $clog2(FIFO_DEPTH)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  dispatch requests a store entry
- alloc_ready  out  1  entry available (count < FIFO_DEPTH)
- alloc_id  out  SID_W  index granted; copied into ROB_ENTRY_t.store_id
- alloc_tail  out  SID_W+1  tail pointer with wrap bit; dispatch snapshots it into each load
- exec_valid  in  1  store AGU result valid
- exec_id  in  SID_W  entry to fill
- exec_addr  in  ADDR_WIDTH  store address
- exec_data  in  DATA_WIDTH  store data, right-aligned
- exec_funct3  in  3  000 sb, 001 sh, 010 sw
- commit_valid  in  1  ROB retires a store
- commit_id  in  SID_W  retiring store_id
- flush  in  1  mispredict recovery; discard all uncommitted entries
- mem_req_valid  out  1  head entry committed and pending
- mem_req_ready  in  1  memory accepts the write
- mem_req_addr / mem_req_data / mem_req_funct3  out  ADDR_WIDTH / DATA_WIDTH / 3  head store
- fwd_valid  in  1  load lookup
- fwd_addr  in  ADDR_WIDTH  load address
- fwd_tail  in  SID_W+1  load's alloc_tail snapshot; older stores are [head, fwd_tail)
- fwd_hit  out  1  forward fwd_data
- fwd_data  out  DATA_WIDTH  word of youngest matching older sw
- fwd_stall  out  1  load must retry

## Operation
- Entry state: FREE → ALLOC (alloc) → READY (exec) → COMMITTED (commit) → FREE (drain handshake).
- Pointers head and tail are SID_W+1 bits. count = tail − head modulo 2^(SID_W+1). Empty: head == tail. Full: count == FIFO_DEPTH.
- Alloc: when alloc_valid && alloc_ready && !flush, entry[tail] becomes ALLOC and tail increments.
- Exec: writes addr, data and funct3, and moves the entry to READY. An exec to a FREE entry is ignored.
- Commit: moves the entry to READY → COMMITTED and increments ncommit. Commits arrive in order, so committed entries are always contiguous from head. A commit to a non-READY entry is illegal and the bench asserts on it.
- Drain: mem_req_valid = entry[head] is COMMITTED. On mem_req_valid && mem_req_ready, the entry becomes FREE, head increments and ncommit decrements.
- Flush: tail <= head + ncommit, evaluated after same-cycle commit and drain. All entries at or beyond the new tail become FREE. alloc is ignored in a flush cycle.
- Forwarding (combinational) scans [head, fwd_tail) from youngest to oldest and stops at the first decision:
  - ALLOC entry (address unknown) → fwd_stall=1.
  - READY/COMMITTED entry with addr[ADDR_WIDTH-1:2] == fwd_addr[ADDR_WIDTH-1:2]:
    - sw → fwd_hit=1 and fwd_data = its data.
    - sb/sh → fwd_stall=1.
  - No decision → hit=0, stall=0, and the load reads memory.
  - When fwd_valid=0, both hit and stall are 0.

## Timing
- Reset values: head=tail=ncommit=0, all entries FREE, alloc_ready=1, alloc_id=0, alloc_tail=0, mem_req_valid=0, mem_req_* outputs=0, fwd_hit=0, fwd_stall=0, fwd_data=0.
- alloc_ready, alloc_id, alloc_tail and mem_req_* are driven from registers. fwd_* outputs are combinational from registers and fwd inputs.
- Exec and commit state is visible to the forward scan and to mem_req_valid the following cycle.
- Drain throughput is one store per cycle. The next head is presented the cycle after the handshake.
- When full, alloc_ready=0 even in a cycle where the buffer drains; there is no same-cycle bypass.
- Pointer wrap at 2^(SID_W+1) is natural modulo arithmetic.
- Reset asserted mid-drain drops mem_req_valid immediately, because the reset is asynchronous.

## Configuration
- STORE_BUFFER_FWD_EN defined: forwarding operates as described above.
- STORE_BUFFER_FWD_EN undefined:
  - No address comparators.
  - fwd_hit=0 and fwd_data=0.
  - fwd_stall=1 whenever fwd_valid and [head, fwd_tail) is non-empty.

## Test plan
- Reset, then 8 allocs → alloc_id 0..7 and alloc_ready=0 after the 8th. A 9th alloc_valid is ignored.
- Alloc id0; exec addr 0x100, data 0xDEADBEEF, sw; commit 0; mem_req_ready=1 → one cycle later mem_req_valid=1 with addr 0x100 and data 0xDEADBEEF, then the buffer is empty.
- Two sw stores to 0x200 (data 0x11, then 0x22), then a load at 0x202 with fwd_tail=2 → fwd_hit=1, fwd_data=0x22. Undefined macro → fwd_stall=1.
- Older store still ALLOC, then load at 0x300 → fwd_stall=1. Older sb at 0x300, then load at 0x300 → fwd_stall=1.
- 4 allocs, id0 committed, flush → tail=1 and count=1. The next alloc_id is 1 and entry 0 still drains.
- Hold mem_req_ready=0 for 5 cycles with id0 committed → mem_req_valid stays 1 with stable fields, and exactly one write occurs when ready rises.
